// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue sitting between a variable-latency instruction
// memory and the fetch/decode pipeline register. It issues sequential 16-bit
// instruction reads (at most one outstanding) and buffers up to DEPTH fetched
// words together with their incremented PCs. The oldest entry is presented to
// decode. A redirect (branch/jump/exception) empties the queue, restarts
// fetch at redirect_pc and turns any in-flight read into a squashed one whose
// data is discarded when it finally returns.
//
// Parameters
//   DEPTH        queue entries, power of two in 2..16
//   AW           PC / instruction address width
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   redirect     flush queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address, sampled when redirect=1
//   halt         level; blocks issue of new memory requests
//   imem_req     memory read request, held until imem_ack
//   imem_addr    memory read address, stable while imem_req=1
//   imem_ack     one-cycle acknowledge, imem_data valid in that cycle
//   imem_data    returned instruction word
//   deq          decode consumes the head entry this cycle
//   Instruction  head instruction, NOP (16'h0800) when empty
//   PC_Inc       head entry's fetch address + 2, zero when empty
//   Valid_PC     queue is non-empty
//   occupancy    number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     halt,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic                     imem_ack,
  input  logic [15:0]              imem_data,
  input  logic                     deq,
  output logic [15:0]              Instruction,
  output logic [AW-1:0]            PC_Inc,
  output logic                     Valid_PC,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_TWO  = AW'(2);
  localparam logic [15:0]   NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   pc_r;
  logic [AW-1:0]   req_addr_r;
  logic            req_r;

  logic [15:0]     instr_mem_r [DEPTH];
  logic [AW-1:0]   pcinc_mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;

  logic            start_s;
  logic            push_s;
  logic            pop_s;
  logic [AW-1:0]   next_pc_s;

  // Transaction decode: when a request starts, when returned data is kept
  // and when the head entry is really consumed.
  always_comb begin
    start_s   = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    next_pc_s = req_addr_r + ADDR_TWO;   // wraps modulo 2^AW
    // A new read may only start when its slot is guaranteed free; since only
    // this read can push, checking count now reserves the slot.
    if ((state_r == ST_IDLE) && !redirect && !halt && (count_r < DEPTH_C)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    // Data returning in the same cycle as a redirect belongs to the old
    // stream and is dropped.
    if ((state_r == ST_WAIT) && imem_ack && !redirect) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (deq && (count_r != CNT_ZERO) && !redirect) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Fetch control FSM: fetch pc, request address and registered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= ADDR_ZERO;
      req_addr_r <= ADDR_ZERO;
      req_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r    <= ST_WAIT;
            req_addr_r <= pc_r;
            req_r      <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            req_r      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            // Ack together with redirect completes the read; nothing left
            // to squash, so go straight back to IDLE.
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            if (!redirect) begin
              pc_r <= next_pc_s;
            end else begin
              pc_r <= redirect_pc;
            end
          end else if (redirect) begin
            state_r <= ST_SQUASH;
            req_r   <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
            req_r   <= 1'b1;
          end
        end
        ST_SQUASH: begin
          // Keep the abandoned request alive until memory answers it.
          if (imem_ack) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
          end else begin
            state_r <= ST_SQUASH;
            req_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
      if (redirect) begin
        pc_r <= redirect_pc;
      end
    end
  end

  // Queue storage: written only on a kept memory return.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= imem_data;
      pcinc_mem_r[tail_r] <= next_pc_s;
    end
  end

  // Queue pointers and entry count; redirect empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (redirect) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation to decode; storage is only read when non-empty so
  // imem_data never reaches the outputs in the cycle it arrives.
  always_comb begin
    Valid_PC    = 1'b0;
    Instruction = NOP_INSTR;
    PC_Inc      = ADDR_ZERO;
    if (count_r != CNT_ZERO) begin
      Valid_PC    = 1'b1;
      Instruction = instr_mem_r[head_r];
      PC_Inc      = pcinc_mem_r[head_r];
    end else begin
      Valid_PC    = 1'b0;
      Instruction = NOP_INSTR;
      PC_Inc      = ADDR_ZERO;
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = req_addr_r;
  assign occupancy = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. A queue-based reference model tracks the
// buffered entries, the fetch pc and the outstanding read; the memory
// responder is driven from that model so stimulus never depends on the DUT.
// A single compare process checks every DUT output against the model after
// each rising edge, and directed scenarios pin the model with literals.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        deq;
  logic [15:0] Instruction;
  logic [15:0] PC_Inc;
  logic        Valid_PC;
  logic [2:0]  occupancy;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .deq         (deq),
    .Instruction (Instruction),
    .PC_Inc      (PC_Inc),
    .Valid_PC    (Valid_PC),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcinc;
  } ent_t;

  // reference model state
  ent_t        m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_raddr;
  bit          m_busy;
  bit          m_drop;
  int          m_wait;

  // memory responder controls
  int          mem_lat;
  bit          ovr_en;
  logic [15:0] ovr_val;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition never reached within cycle budget", name);
  endtask

  // compare every output with the model after each rising edge
  always @(posedge clk) begin : cmp
    bit          ev;
    logic [15:0] ei;
    logic [15:0] ep;
    #2;
    if (chk_en) begin
      ev = (m_q.size() > 0);
      ei = ev ? m_q[0].instr : 16'h0800;
      ep = ev ? m_q[0].pcinc : 16'h0000;
      chk("imem_req",    {31'd0, imem_req},   {31'd0, m_busy});
      chk("imem_addr",   {16'd0, imem_addr},  {16'd0, m_raddr});
      chk("Valid_PC",    {31'd0, Valid_PC},   {31'd0, ev});
      chk("Instruction", {16'd0, Instruction}, {16'd0, ei});
      chk("PC_Inc",      {16'd0, PC_Inc},     {16'd0, ep});
      chk("occupancy",   {29'd0, occupancy},  32'(m_q.size()));
    end
  end

  // One clock: called at a falling edge, drives inputs, advances the model
  // at the rising edge and returns at the next falling edge.
  task automatic step(input bit d, input bit rd, input logic [15:0] rpc, input bit h);
    bit          ack;
    logic [15:0] dat;
    ent_t        e;
    int          sz;
    ack = m_busy && (m_wait >= mem_lat);
    dat = ack ? (ovr_en ? ovr_val : mem_word(m_raddr)) : 16'hDEAD;
    deq = d; redirect = rd; redirect_pc = rpc; halt = h;
    imem_ack = ack; imem_data = dat;
    @(posedge clk);
    sz = m_q.size();
    if (m_busy) begin
      if (ack) begin
        if (!m_drop && !rd) begin
          e.instr = dat;
          e.pcinc = m_raddr + 16'd2;
          m_q.push_back(e);
          m_pc = m_raddr + 16'd2;
        end
        m_busy = 1'b0;
        m_drop = 1'b0;
        ovr_en = 1'b0;
      end else begin
        m_wait++;
        if (rd) m_drop = 1'b1;
      end
    end else if (!rd && !h && sz < DEPTH) begin
      m_busy  = 1'b1;
      m_raddr = m_pc;
      m_wait  = 0;
    end
    if (!rd && d && sz > 0) void'(m_q.pop_front());
    if (rd) begin
      m_q.delete();
      m_pc = rpc;
    end
    @(negedge clk);
  endtask

  // Assert reset at the current time (async), check reset values, release at
  // a falling edge.
  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0;
    deq = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    imem_ack = 1'b0; imem_data = 16'h0000;
    #1;
    chk("rst_imem_req",    {31'd0, imem_req},    32'd0);
    chk("rst_imem_addr",   {16'd0, imem_addr},   32'h0000);
    chk("rst_Valid_PC",    {31'd0, Valid_PC},    32'd0);
    chk("rst_Instruction", {16'd0, Instruction}, 32'h0800);
    chk("rst_PC_Inc",      {16'd0, PC_Inc},      32'h0000);
    chk("rst_occupancy",   {29'd0, occupancy},   32'd0);
    m_q.delete();
    m_pc = 16'h0000; m_raddr = 16'h0000;
    m_busy = 1'b0; m_drop = 1'b0; m_wait = 0;
    mem_lat = 0; ovr_en = 1'b0; ovr_val = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    #2;
    do_reset();

    // fill: memory acks one cycle after the request rises, no dequeue
    mem_lat = 1;
    repeat (16) step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("fill_occ",   {29'd0, occupancy},   32'd4);
    chk("fill_req",   {31'd0, imem_req},    32'd0);
    chk("fill_instr", {16'd0, Instruction}, 32'h0000C3A5);
    chk("fill_pcinc", {16'd0, PC_Inc},      32'h0002);
    chk("fill_addr",  {16'd0, imem_addr},   32'h0006);

    // drain: continuous dequeue, 5th request to 0x0008 after first deq
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("drain1_occ",   {29'd0, occupancy},   32'd3);
    chk("drain1_instr", {16'd0, Instruction}, 32'h0000C3A7);
    chk("drain1_pcinc", {16'd0, PC_Inc},      32'h0004);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("drain2_req",  {31'd0, imem_req},  32'd1);
    chk("drain2_addr", {16'd0, imem_addr}, 32'h0008);
    repeat (12) step(1'b1, 1'b0, 16'h0000, 1'b0);

    // squash: request to 0x0004 outstanding, redirect to 0x0100, late ack 0xBEEF
    do_reset();
    mem_lat = 0;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_busy && m_raddr == 16'h0004 && m_wait == 0) begin hit = 1'b1; break; end
      step(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    if (!hit) timeout_fail("squash_setup");
    mem_lat = 3; ovr_en = 1'b1; ovr_val = 16'hBEEF;
    step(1'b1, 1'b1, 16'h0100, 1'b0);
    chk("squash_valid", {31'd0, Valid_PC}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("squash_occ", {29'd0, occupancy}, 32'd0);
    end
    chk("squash_req",  {31'd0, imem_req},  32'd1);
    chk("squash_addr", {16'd0, imem_addr}, 32'h0100);
    mem_lat = 0;
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("squash_instr", {16'd0, Instruction}, 32'h0000C2A5);
    chk("squash_pcinc", {16'd0, PC_Inc},      32'h0102);

    // simultaneous push and deq at count 3
    do_reset();
    mem_lat = 0;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_busy && m_q.size() == 3) begin hit = 1'b1; break; end
      step(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    if (!hit) timeout_fail("pushpop_setup");
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("pushpop_occ",   {29'd0, occupancy},   32'd3);
    chk("pushpop_instr", {16'd0, Instruction}, 32'h0000C3A7);
    chk("pushpop_pcinc", {16'd0, PC_Inc},      32'h0004);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("pushpop_tail_instr", {16'd0, Instruction}, 32'h0000C3A3);
    chk("pushpop_tail_pcinc", {16'd0, PC_Inc},      32'h0008);

    // halt with 2 entries queued and one read outstanding
    do_reset();
    mem_lat = 0;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_busy && m_q.size() == 2) begin hit = 1'b1; break; end
      step(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    if (!hit) timeout_fail("halt_setup");
    mem_lat = 2;
    repeat (6) step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("halt_occ", {29'd0, occupancy}, 32'd3);
    chk("halt_req", {31'd0, imem_req},  32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("unhalt_req",  {31'd0, imem_req},  32'd1);
    chk("unhalt_addr", {16'd0, imem_addr}, 32'h0006);

    // pc wrap: redirect to 0xFFFE, ack 0x1234
    do_reset();
    step(1'b0, 1'b1, 16'hFFFE, 1'b0);
    chk("wrap_idle_req", {31'd0, imem_req}, 32'd0);
    mem_lat = 0; ovr_en = 1'b1; ovr_val = 16'h1234;
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_addr", {16'd0, imem_addr}, 32'hFFFE);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_instr", {16'd0, Instruction}, 32'h1234);
    chk("wrap_pcinc", {16'd0, PC_Inc},      32'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("wrap_next_addr", {16'd0, imem_addr}, 32'h0000);
    chk("wrap_next_req",  {31'd0, imem_req},  32'd1);

    // redirect in the same cycle as the ack: data dropped, no squash
    step(1'b0, 1'b1, 16'h0200, 1'b0);
    chk("redir_ack_occ", {29'd0, occupancy}, 32'd0);
    chk("redir_ack_req", {31'd0, imem_req},  32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("redir_ack_addr", {16'd0, imem_addr}, 32'h0200);

    // asynchronous reset while a read is outstanding
    do_reset();
    repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
